// File: rtl/pll_pkg.sv
// rtl/pll_pkg.sv - shared state encoding and default loop parameters for the PLL loop controller
package pll_pkg;

    typedef enum logic [1:0] {
        PLL_IDLE   = 2'd0,
        PLL_ACQ    = 2'd1,
        PLL_TRACK  = 2'd2,
        PLL_LOCKED = 2'd3
    } pll_state_t;

    localparam int CTRL_W_DEF    = 10;
    localparam int KI_SHIFT_DEF  = 4;
    localparam int KP_DEF        = 4;
    localparam int ACQ_SHIFT_DEF = 3;
    localparam int WIN_DEF       = 64;
    localparam int TRK_THR_DEF   = 16;
    localparam int LOCK_THR_DEF  = 2;
    localparam int LOCK_WINS_DEF = 4;

endpackage

// File: rtl/pll_lock_detect.sv
// rtl/pll_lock_detect.sv - window, error and good-window counters producing per-window lock strobes
module pll_lock_detect
    import pll_pkg::*;
#(
    parameter int WIN       = WIN_DEF,
    parameter int TRK_THR   = TRK_THR_DEF,
    parameter int LOCK_THR  = LOCK_THR_DEF,
    parameter int LOCK_WINS = LOCK_WINS_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic track,
    input  logic err_nz,
    output logic win_end,
    output logic win_good,
    output logic win_bad_trk,
    output logic win_bad_lock,
    output logic lock_ready
);

    localparam int WIN_W  = $clog2(WIN);
    localparam int CNT_W  = $clog2(WIN + 1);
    localparam int GOOD_W = $clog2(LOCK_WINS + 1);

    logic [WIN_W-1:0]  win_cnt;
    logic [CNT_W-1:0]  err_cnt;
    logic [CNT_W-1:0]  err_tot;
    logic [GOOD_W-1:0] good_cnt;

    // The window's last cycle is judged with its own error already included.
    assign err_tot      = err_cnt + CNT_W'(err_nz);
    assign win_end      = run && (win_cnt == WIN_W'(WIN - 1));
    assign win_good     = win_end && (err_tot <= CNT_W'(LOCK_THR));
    assign win_bad_trk  = win_end && (err_tot >  CNT_W'(TRK_THR));
    assign win_bad_lock = win_end && (err_tot >  CNT_W'(LOCK_THR));
    // The window that completes this run of good windows is the one now ending.
    assign lock_ready   = (good_cnt == GOOD_W'(LOCK_WINS - 1));

    always_ff @(posedge clk) begin
        if (rst || !run) begin
            win_cnt  <= '0;
            err_cnt  <= '0;
            good_cnt <= '0;
        end else if (win_end) begin
            win_cnt  <= '0;
            err_cnt  <= '0;
            good_cnt <= (track && win_good) ? good_cnt + GOOD_W'(1) : '0;
        end else begin
            win_cnt  <= win_cnt + WIN_W'(1);
            err_cnt  <= err_tot;
        end
    end

endmodule

// File: rtl/pll_loop_ctrl.sv
// rtl/pll_loop_ctrl.sv - PI loop filter and acquire/track/lock sequencer driving the DCO control word
module pll_loop_ctrl
    import pll_pkg::*;
#(
    parameter int CTRL_W    = CTRL_W_DEF,
    parameter int KI_SHIFT  = KI_SHIFT_DEF,
    parameter int KP        = KP_DEF,
    parameter int ACQ_SHIFT = ACQ_SHIFT_DEF,
    parameter int WIN       = WIN_DEF,
    parameter int TRK_THR   = TRK_THR_DEF,
    parameter int LOCK_THR  = LOCK_THR_DEF,
    parameter int LOCK_WINS = LOCK_WINS_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              up,
    input  logic              dn,
    output logic [CTRL_W-1:0] ctrl_word,
    output logic [1:0]        state,
    output logic              locked,
    output logic              lock_lost,
    output logic              sat
);

    localparam int ACC_W = CTRL_W + KI_SHIFT;
    localparam int SUM_W = CTRL_W + 2;
    localparam logic signed [ACC_W-1:0] ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [CTRL_W-1:0]       MID      = {1'b1, {(CTRL_W-1){1'b0}}};
    localparam logic signed [SUM_W-1:0] MID_S    = $signed({2'b00, MID});
    localparam logic signed [SUM_W-1:0] CTRL_TOP = $signed({2'b00, {CTRL_W{1'b1}}});
    localparam logic signed [SUM_W-1:0] KP_S     = SUM_W'(KP);

    pll_state_t state_q, state_d;
    logic up_q, dn_q;
    logic signed [1:0]       err;
    logic signed [ACC_W:0]   step;
    logic signed [ACC_W:0]   integ_sum;
    logic signed [ACC_W-1:0] integ, integ_nxt;
    logic signed [SUM_W-1:0] ctrl_sum;
    logic [CTRL_W-1:0]       ctrl_nxt;
    logic run, lost_d;
    logic win_end, win_good, win_bad_trk, win_bad_lock, lock_ready;

    assign state  = state_q;
    assign locked = (state_q == PLL_LOCKED);
    assign run    = en && (state_q != PLL_IDLE);

    always_comb begin
        err = 2'sd0;
        if (up_q && !dn_q) err = 2'sd1;
        else if (dn_q && !up_q) err = -2'sd1;
    end

    // Saturating integrator, one bit wider so the overflow is visible before clamping.
    always_comb begin
        step = (ACC_W+1)'(err);
        if (state_q == PLL_ACQ) step = step <<< ACQ_SHIFT;
        integ_sum = (ACC_W+1)'(integ) + step;
        integ_nxt = integ_sum[ACC_W-1:0];
        if (integ_sum > (ACC_W+1)'(ACC_MAX)) integ_nxt = ACC_MAX;
        else if (integ_sum < (ACC_W+1)'(ACC_MIN)) integ_nxt = ACC_MIN;
    end

    always_comb begin
        ctrl_sum = MID_S + SUM_W'(integ_nxt >>> KI_SHIFT) + SUM_W'(err) * KP_S;
        ctrl_nxt = ctrl_sum[CTRL_W-1:0];
        if (ctrl_sum < 0) ctrl_nxt = '0;
        else if (ctrl_sum > CTRL_TOP) ctrl_nxt = {CTRL_W{1'b1}};
    end

    always_comb begin
        state_d = state_q;
        lost_d  = 1'b0;
        if (!en) begin
            state_d = PLL_IDLE;
        end else begin
            case (state_q)
                PLL_IDLE:   state_d = PLL_ACQ;
                PLL_ACQ:    if (win_end && !win_bad_trk) state_d = PLL_TRACK;
                PLL_TRACK: begin
                    if (win_bad_trk) state_d = PLL_ACQ;
                    else if (win_good && lock_ready) state_d = PLL_LOCKED;
                end
                PLL_LOCKED: begin
                    if (win_bad_lock) begin
                        state_d = PLL_TRACK;
                        lost_d  = 1'b1;
                    end
                end
                default:    state_d = PLL_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            up_q      <= 1'b0;
            dn_q      <= 1'b0;
            state_q   <= PLL_IDLE;
            integ     <= '0;
            ctrl_word <= MID;
            sat       <= 1'b0;
            lock_lost <= 1'b0;
        end else begin
            up_q      <= up;
            dn_q      <= dn;
            state_q   <= state_d;
            lock_lost <= lost_d;
            // IDLE holds the loop; leaving any active state through en=0 recentres it.
            if (state_q != PLL_IDLE) begin
                if (!en) begin
                    integ     <= '0;
                    ctrl_word <= MID;
                    sat       <= 1'b0;
                end else begin
                    integ     <= integ_nxt;
                    ctrl_word <= ctrl_nxt;
                    sat       <= (integ_nxt == ACC_MAX) || (integ_nxt == ACC_MIN);
                end
            end
        end
    end

    pll_lock_detect #(
        .WIN       (WIN),
        .TRK_THR   (TRK_THR),
        .LOCK_THR  (LOCK_THR),
        .LOCK_WINS (LOCK_WINS)
    ) u_lock_detect (
        .clk          (clk),
        .rst          (rst),
        .run          (run),
        .track        (state_q == PLL_TRACK),
        .err_nz       (err != 2'sd0),
        .win_end      (win_end),
        .win_good     (win_good),
        .win_bad_trk  (win_bad_trk),
        .win_bad_lock (win_bad_lock),
        .lock_ready   (lock_ready)
    );

endmodule

// File: doc/pll_loop_ctrl.md
# pll_loop_ctrl

Digital loop controller that sits between the phase-frequency detector and the DCO. Each cycle it samples the detector's `up`/`dn` outputs, turns them into a signed error and runs a proportional-integral loop filter to produce the DCO control word. A window-based lock detector sequences the loop through acquire, track and locked phases, and raises `locked` and `lock_lost`.

## Interface
- `CTRL_W`, 10: DCO control word width. Mid-code `MID = 2^(CTRL_W-1)`.
- `KI_SHIFT`, 4: integrator right-shift. The integrator is `ACC_W = CTRL_W+KI_SHIFT` bits, signed.
- `KP`, 4: proportional gain, as an integer multiplier on the error.
- `ACQ_SHIFT`, 3: integrator step left-shift, applied in ACQ only.
- `WIN`, 64: lock-detector window length, in cycles.
- `TRK_THR`, 16: maximum error cycles per window allowed to stay out of ACQ.
- `LOCK_THR`, 2: maximum error cycles per window that count as a good window.
- `LOCK_WINS`, 4: consecutive good windows required to declare lock.

Ports:
- `clk` in 1: single clock. All logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: loop enable. Level-sensitive.
- `up` in 1: PFD up output, synchronous to `clk`.
- `dn` in 1: PFD down output, synchronous to `clk`.
- `ctrl_word` out CTRL_W: DCO control word, registered.
- `state` out 2: IDLE=0, ACQ=1, TRACK=2, LOCKED=3.
- `locked` out 1: high exactly while in LOCKED.
- `lock_lost` out 1: one-cycle pulse on the LOCKED->TRACK transition.
- `sat` out 1: high while the integrator sits at either rail.

## Operation
**Reset (`rst`=1)** sets:
- `ctrl_word`=MID
- integrator=0, all counters=0
- `state`=IDLE
- `locked`=0, `lock_lost`=0, `sat`=0

**Input stage**
- `up`/`dn` are registered into `up_q`/`dn_q`.
- `err` = +1 if `up_q`&!`dn_q`; -1 if `dn_q`&!`up_q`; otherwise 0. Both high counts as 0.

**Integrator update**
- In ACQ: `integ_nxt` = sat(integ + (err<<ACQ_SHIFT)).
- In TRACK and LOCKED: `integ_nxt` = sat(integ + err).
- Saturation limits are `[-2^(ACC_W-1), 2^(ACC_W-1)-1]`.
- `sat` is set when `integ_nxt` equals either limit.

**Control word**
- `ctrl_word` <= clamp(MID + (`integ_nxt`>>>KI_SHIFT) + err*KP, 0, 2^CTRL_W-1).
- The sum is evaluated at `CTRL_W+2` signed bits, with an arithmetic shift.

**Lock detector**
- `win_cnt` runs 0..WIN-1 in every state except IDLE.
- `err_cnt` counts cycles with err≠0, including the window's last cycle.
- At window end (`win_cnt`==WIN-1), the window is evaluated, `err_cnt` restarts at 0 and `win_cnt` wraps.

**State machine** (transitions are evaluated at window end unless noted):
- IDLE -> ACQ when `en`=1.
- ACQ -> TRACK if `err_cnt`≤TRK_THR; otherwise stay in ACQ.
- TRACK:
  - If `err_cnt`>TRK_THR: go to ACQ and set `good_cnt`=0.
  - Else if `err_cnt`≤LOCK_THR: `good_cnt`++. When `good_cnt` reaches LOCK_WINS, go to LOCKED.
  - Otherwise: `good_cnt`=0.
- LOCKED -> TRACK if `err_cnt`>LOCK_THR. Pulse `lock_lost`, set `good_cnt`=0.
- Any state -> IDLE on the next edge when `en`=0 (not gated on window end). Entering IDLE clears the integrator, `win_cnt`, `err_cnt` and `good_cnt`, and drives `ctrl_word`=MID.

**Boundary rules**
- In IDLE the integrator and `ctrl_word` are held, regardless of `up`/`dn`.
- `rst` overrides `en` and any window end in the same cycle.
- A window end and the fall of `en` in the same cycle resolve to IDLE.
- When the integrator is at a rail, further same-sign error holds it there. Opposite-sign error leaves the rail immediately.

## Timing
- `up`/`dn` sampled at edge N -> `err` valid after N -> integrator, `ctrl_word` and `sat` update at edge N+1. Latency is 2 edges from the `up`/`dn` inputs to `ctrl_word`.
- `state`, `locked` and `lock_lost` update on the edge after the window's last cycle.
- `lock_lost` is high for exactly 1 cycle.
- Minimum time from entering ACQ to `locked` is (1+LOCK_WINS)·WIN cycles, i.e. 320 with defaults.

## Structure
- Shared package `pll_pkg`: the state enum (`PLL_IDLE`, `PLL_ACQ`, `PLL_TRACK`, `PLL_LOCKED`) and default widths and gains.
- Sub-module `pll_lock_detect`: the window counter, error counter and good-window counter. It outputs per-window `win_end`, `win_good`, `win_bad_trk` and `win_bad_lock` strobes.
- `pll_loop_ctrl` owns the state machine, integrator and control-word register.

## Test plan
1. **Reset values:** assert `rst` 2 cycles -> `ctrl_word`=512, `state`=0, `locked`=0, `lock_lost`=0, `sat`=0.
2. **ACQ step:** `en`=1, `up`=1/`dn`=0 for 10 samples in ACQ -> integrator=80, `ctrl_word`=512+5+4=521 two edges after the 10th sample.
3. **Acquire to lock:** `en`=1 with `up`=`dn`=0 -> TRACK after 64 cycles, LOCKED after 320 cycles; `locked`=1 on the following edge.
4. **Loss of lock:** from LOCKED, inject 3 single-cycle `up` pulses in one window -> at window end `state`=TRACK, `lock_lost`=1 for exactly 1 cycle, `locked`=0.
5. **Saturation:** hold `up`=1 for 2000 cycles -> `state` stays ACQ, integrator=8191, `sat`=1, `ctrl_word`=1023; then `dn`=1 for one sample -> `sat`=0.
6. **Abort paths:** drop `en` mid-ACQ -> IDLE next edge, `ctrl_word`=512. Assert `rst` in LOCKED -> all reset values next edge.
